hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage RV32I core. Drives stall/flush of PC,
//  IF2ID, ID2EX, EX2MEM, MEM2WB: load-use bubbles, branch/jump redirect flushes, whole-pipe

---
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect flushes, memory-wait freeze with timeout.
// Zero-cycle response: controls are combinational from state and inputs. State and counters are registered.
module hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_load_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_stall_o,
  output logic             if2id_stall_o,
  output logic             if2id_flush_o,
  output logic             id2ex_stall_o,
  output logic             id2ex_flush_o,
  output logic             ex2mem_stall_o,
  output logic             mem2wb_flush_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {RUN, WAIT_MEM, ERR} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            memwait, loaduse, redirect_take;

  assign memwait = mem_req_i & ~mem_ready_i;
  assign loaduse = ex_load_i & ex_reg_write_i & (ex_rd_i != 5'd0) &
                   ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                    (id_use_rs2_i & (id_rs2_i == ex_rd_i)));

  // A redirect while frozen is deferred, so it only counts when it actually flushes.
  always_comb begin
    pc_stall_o     = 1'b0;
    if2id_stall_o  = 1'b0;
    if2id_flush_o  = 1'b0;
    id2ex_stall_o  = 1'b0;
    id2ex_flush_o  = 1'b0;
    ex2mem_stall_o = 1'b0;
    mem2wb_flush_o = 1'b0;
    redirect_take  = 1'b0;
    if (rst) begin
      if2id_flush_o  = 1'b1;
      id2ex_flush_o  = 1'b1;
      mem2wb_flush_o = 1'b1;
    end else if (state == ERR || memwait) begin
      pc_stall_o     = 1'b1;
      if2id_stall_o  = 1'b1;
      id2ex_stall_o  = 1'b1;
      ex2mem_stall_o = 1'b1;
      mem2wb_flush_o = 1'b1;
    end else if (ex_redirect_i) begin
      if2id_flush_o  = 1'b1;
      id2ex_flush_o  = 1'b1;
      redirect_take  = 1'b1;
    end else if (loaduse) begin
      pc_stall_o     = 1'b1;
      if2id_stall_o  = 1'b1;
      id2ex_flush_o  = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nxt    = WAIT_MEM;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      WAIT_MEM: begin
        if (memwait) begin
          if (wait_cnt == WC_W'(TIMEOUT - 1)) state_nxt = ERR;
          else                                wait_cnt_nxt = wait_cnt + 1'b1;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      end
      ERR:     state_nxt = ERR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_o       <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) err_o <= 1'b1;
      if (pc_stall_o && stall_cnt_o != {CNT_W{1'b1}}) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (redirect_take && flush_cnt_o != {CNT_W{1'b1}}) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4 and 4-bit counters so timeout and saturation are reachable.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       use_rs1, use_rs2, ex_load, ex_rw, ex_redirect, mem_req, mem_ready;
  logic       pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, ex2mem_stall, mem2wb_flush;
  logic       err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int n_chk = 0;
  int n_fail = 0;

  // Control vector order: pc_s, if2id_s, if2id_f, id2ex_s, id2ex_f, ex2mem_s, mem2wb_f
  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_RST    = 7'b0010101;
  localparam logic [6:0] C_LDUSE  = 7'b1100100;
  localparam logic [6:0] C_REDIR  = 7'b0010100;
  localparam logic [6:0] C_FREEZE = 7'b1101011;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(use_rs1), .id_use_rs2_i(use_rs2),
    .ex_rd_i(ex_rd), .ex_load_i(ex_load), .ex_reg_write_i(ex_rw), .ex_redirect_i(ex_redirect),
    .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .pc_stall_o(pc_stall), .if2id_stall_o(if2id_stall), .if2id_flush_o(if2id_flush),
    .id2ex_stall_o(id2ex_stall), .id2ex_flush_o(id2ex_flush), .ex2mem_stall_o(ex2mem_stall),
    .mem2wb_flush_o(mem2wb_flush), .err_o(err), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  assign ctl = {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, ex2mem_stall, mem2wb_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_load = 1'b0; ex_rw = 1'b0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_loaduse();
    ex_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
  endtask

  // Advance one clock, then let combinational outputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_err", 32'(err), 0);
    chk("rst_scnt", 32'(stall_cnt), 0);
    chk("rst_fcnt", 32'(flush_cnt), 0);
    rst = 1'b0; #1;
    chk("idle_ctl", 32'(ctl), 32'(C_IDLE));
    tick();

    set_loaduse(); #1;
    chk("lu_ctl", 32'(ctl), 32'(C_LDUSE));
    tick();
    idle(); #1;
    chk("lu_scnt", 32'(stall_cnt), 1);
    chk("lu_after", 32'(ctl), 32'(C_IDLE));

    set_loaduse(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    chk("lu_rd0", 32'(ctl), 32'(C_IDLE));
    set_loaduse(); use_rs1 = 1'b0; #1;
    chk("lu_nouse", 32'(ctl), 32'(C_IDLE));
    set_loaduse(); ex_rw = 1'b0; #1;
    chk("lu_norw", 32'(ctl), 32'(C_IDLE));
    set_loaduse(); ex_load = 1'b0; #1;
    chk("lu_noload", 32'(ctl), 32'(C_IDLE));
    idle(); ex_load = 1'b1; ex_rw = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; use_rs2 = 1'b1; id_rs1 = 5'd9; #1;
    chk("lu_rs2", 32'(ctl), 32'(C_LDUSE));
    tick();
    idle(); #1;
    chk("lu_rs2_scnt", 32'(stall_cnt), 2);

    set_loaduse(); ex_redirect = 1'b1; #1;
    chk("redir_lu_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    idle(); #1;
    chk("redir_fcnt", 32'(flush_cnt), 1);
    chk("redir_scnt", 32'(stall_cnt), 2);

    // Three-cycle memory wait with a redirect pending throughout; redirect must wait for completion.
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait%0d_ctl", i), 32'(ctl), 32'(C_FREEZE));
      tick();
    end
    mem_ready = 1'b1; #1;
    chk("done_ctl", 32'(ctl), 32'(C_REDIR));
    tick();
    idle(); #1;
    chk("done_scnt", 32'(stall_cnt), 5);
    chk("done_fcnt", 32'(flush_cnt), 2);
    chk("done_err", 32'(err), 0);
    chk("done_idle", 32'(ctl), 32'(C_IDLE));
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    chk("memhit_ctl", 32'(ctl), 32'(C_IDLE));
    tick();

    // Abandoned wait, then another three-cycle wait: the wait counter must have restarted.
    idle(); mem_req = 1'b1;
    tick(); tick(); tick();
    mem_req = 1'b0; #1;
    chk("drop_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    mem_req = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b1; #1;
    chk("rewait_err", 32'(err), 0);
    chk("rewait_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    idle(); #1;
    chk("rewait_scnt", 32'(stall_cnt), 11);

    // Timeout: after four wait cycles the controller locks up in ERR.
    mem_req = 1'b1;
    tick(); tick(); tick();
    chk("to3_err", 32'(err), 0);
    chk("to3_scnt", 32'(stall_cnt), 14);
    tick();
    chk("to4_err", 32'(err), 1);
    chk("to4_scnt", 32'(stall_cnt), 15);
    idle(); ex_redirect = 1'b1; #1;
    chk("err_ctl", 32'(ctl), 32'(C_FREEZE));
    for (int i = 0; i < 5; i++) tick();
    chk("err_sticky", 32'(err), 1);
    chk("err_ctl_hold", 32'(ctl), 32'(C_FREEZE));
    chk("scnt_sat", 32'(stall_cnt), 15);
    chk("fcnt_err", 32'(flush_cnt), 2);

    rst = 1'b1; #1;
    chk("rst2_ctl", 32'(ctl), 32'(C_RST));
    tick();
    rst = 1'b0; idle(); #1;
    chk("rst2_err", 32'(err), 0);
    chk("rst2_scnt", 32'(stall_cnt), 0);
    chk("rst2_fcnt", 32'(flush_cnt), 0);
    chk("rst2_ctl_run", 32'(ctl), 32'(C_IDLE));

    // Flush counter saturation after 17 redirects.
    ex_redirect = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("fcnt_sat", 32'(flush_cnt), 15);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
